// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM state and grant encoding.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   // Which requester a pick selects; GNT_I also doubles as the value of last_i
   // after a fetch completes.
   typedef enum logic {
      GNT_D = 1'b0,
      GNT_I = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational round-robin picker: a lone request wins; on a tie the side
// that was not served last wins (last_i=1 means fetch was served last).
module mem_arbiter_pick
   import mem_arbiter_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_i,
   output logic grant_valid,
   output logic grant_i
);

   grant_t gnt;

   // Pick the winner; meaningful only while grant_valid is high
   always_comb begin
      gnt = GNT_D;
      if (i_req && (!d_req || !last_i)) begin
         gnt = GNT_I;
      end
   end

   assign grant_valid = i_req | d_req;
   assign grant_i     = (gnt == GNT_I);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (fetch read port + data load/store port) onto
// one registered memory bus. Grants alternate round-robin; address/data are
// latched into the bus registers at grant. Optional performance counters are
// enabled by defining MEM_ARBITER_PERFCNT_EN.
//
// state  | meaning
// IDLE   | no transaction on the bus
// BUSY_I | fetch transaction in flight, waiting for bus_ack
// BUSY_D | data transaction in flight, waiting for bus_ack
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              Nrst,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_req,
   output logic              i_wait,
   output logic [DATA_W-1:0] i_data,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_wait,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_req,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata
`ifdef MEM_ARBITER_PERFCNT_EN
   ,
   output logic [31:0]       perf_i_grants,
   output logic [31:0]       perf_d_grants,
   output logic [31:0]       perf_conflict
`endif
);

   state_t              state_q, state_d;
   logic                last_i_q, last_i_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic                bus_req_q, bus_req_d;
   logic                bus_we_q, bus_we_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;

   logic last_i_pick;
   logic grant_valid;
   logic grant_i;
   logic busy_ack;
   logic take_grant;

   // On an ack edge the pick must already see the side that just completed,
   // so the picker's history input is taken from the current BUSY state.
   always_comb begin
      last_i_pick = last_i_q;
      if (state_q == BUSY_I) begin
         last_i_pick = 1'b1;
      end else if (state_q == BUSY_D) begin
         last_i_pick = 1'b0;
      end
   end

   mem_arbiter_pick u_pick (
      .i_req       (i_req),
      .d_req       (d_req),
      .last_i      (last_i_pick),
      .grant_valid (grant_valid),
      .grant_i     (grant_i)
   );

   assign busy_ack   = (state_q != IDLE) && bus_ack;
   assign take_grant = ((state_q == IDLE) || busy_ack) && grant_valid;

   // Next-state and bus register loads; a completion and a new grant can
   // coincide, giving back-to-back transactions without an idle cycle.
   always_comb begin
      state_d     = state_q;
      last_i_d    = last_i_q;
      bus_addr_d  = bus_addr_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_wdata_d = bus_wdata_q;
      if (busy_ack) begin
         last_i_d  = (state_q == BUSY_I);
         state_d   = IDLE;
         bus_req_d = 1'b0;
      end
      if (take_grant) begin
         bus_req_d = 1'b1;
         if (grant_i) begin
            state_d     = BUSY_I;
            bus_addr_d  = i_addr;
            bus_we_d    = 1'b0;
            bus_wdata_d = '0;
         end else begin
            state_d     = BUSY_D;
            bus_addr_d  = d_addr;
            bus_we_d    = d_we;
            bus_wdata_d = d_wdata;
         end
      end
   end

   // State and bus registers
   always_ff @(posedge clk or negedge Nrst) begin
      if (!Nrst) begin
         state_q     <= IDLE;
         last_i_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_i_q    <= last_i_d;
         bus_addr_q  <= bus_addr_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_wdata_q <= bus_wdata_d;
      end
   end

   // A requester that dropped its request mid-flight gets no wait-low pulse
   assign i_wait    = !((state_q == BUSY_I) && bus_ack && i_req);
   assign d_wait    = !((state_q == BUSY_D) && bus_ack && d_req);
   assign i_data    = bus_rdata;
   assign d_rdata   = bus_rdata;
   assign bus_addr  = bus_addr_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_wdata = bus_wdata_q;

`ifdef MEM_ARBITER_PERFCNT_EN
   logic [31:0] perf_i_q, perf_i_d;
   logic [31:0] perf_d_q, perf_d_d;
   logic [31:0] perf_c_q, perf_c_d;

   // Grant counts per side, plus cycles in which any requester is stalled
   always_comb begin
      perf_i_d = perf_i_q;
      perf_d_d = perf_d_q;
      perf_c_d = perf_c_q;
      if (take_grant && grant_i) begin
         perf_i_d = perf_i_q + 32'd1;
      end
      if (take_grant && !grant_i) begin
         perf_d_d = perf_d_q + 32'd1;
      end
      if ((i_req && i_wait) || (d_req && d_wait)) begin
         perf_c_d = perf_c_q + 32'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge Nrst) begin
      if (!Nrst) begin
         perf_i_q <= '0;
         perf_d_q <= '0;
         perf_c_q <= '0;
      end else begin
         perf_i_q <= perf_i_d;
         perf_d_q <= perf_d_d;
         perf_c_q <= perf_c_d;
      end
   end

   assign perf_i_grants = perf_i_q;
   assign perf_d_grants = perf_d_q;
   assign perf_conflict = perf_c_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change 1 time unit
// after each rising edge; outputs are checked 1 unit later.
module tb_mem_arbiter;

   logic        clk;
   logic        Nrst;
   logic [31:0] i_addr;
   logic        i_req;
   logic        i_wait;
   logic [31:0] i_data;
   logic [31:0] d_addr;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_wdata;
   logic        d_wait;
   logic [31:0] d_rdata;
   logic [31:0] bus_addr;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
`ifdef MEM_ARBITER_PERFCNT_EN
   logic [31:0] perf_i_grants;
   logic [31:0] perf_d_grants;
   logic [31:0] perf_conflict;
`endif

   int n_err;
   int n_chk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .Nrst      (Nrst),
      .i_addr    (i_addr),
      .i_req     (i_req),
      .i_wait    (i_wait),
      .i_data    (i_data),
      .d_addr    (d_addr),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_wdata   (d_wdata),
      .d_wait    (d_wait),
      .d_rdata   (d_rdata),
      .bus_addr  (bus_addr),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
`ifdef MEM_ARBITER_PERFCNT_EN
      ,
      .perf_i_grants (perf_i_grants),
      .perf_d_grants (perf_d_grants),
      .perf_conflict (perf_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_err = 0;
      n_chk = 0;
      Nrst = 1'b0;
      i_addr = '0; i_req = 1'b0;
      d_addr = '0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
      bus_ack = 1'b0; bus_rdata = '0;
      #2;
      chk("rst_bus_req",   32'(bus_req), 32'd0);
      chk("rst_bus_we",    32'(bus_we), 32'd0);
      chk("rst_bus_addr",  bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_i_wait",    32'(i_wait), 32'd1);
      chk("rst_d_wait",    32'(d_wait), 32'd1);
      cyc(); Nrst = 1'b1;

      // Fetch only, ack two cycles after bus_req rises
      cyc(); i_req = 1'b1; i_addr = 32'h100; #1;
      chk("f_idle_wait", 32'(i_wait), 32'd1);
      chk("f_idle_req",  32'(bus_req), 32'd0);
      cyc(); #1;
      chk("f_bus_req",  32'(bus_req), 32'd1);
      chk("f_bus_addr", bus_addr, 32'h100);
      chk("f_bus_we",   32'(bus_we), 32'd0);
      chk("f_wait_n1",  32'(i_wait), 32'd1);
      cyc(); #1;
      chk("f_wait_n2",  32'(i_wait), 32'd1);
      chk("f_hold_req", 32'(bus_req), 32'd1);
      cyc(); bus_ack = 1'b1; bus_rdata = 32'hCAFE0001; #1;
      chk("f_wait_ack", 32'(i_wait), 32'd0);
      chk("f_i_data",   i_data, 32'hCAFE0001);
      chk("f_d_wait",   32'(d_wait), 32'd1);
      // i_req was still high at the ack edge, so a second fetch was granted
      cyc(); i_req = 1'b0; #1;
      chk("f_regrant_req", 32'(bus_req), 32'd1);
      chk("f_drop_wait",   32'(i_wait), 32'd1);
      cyc(); bus_ack = 1'b0; #1;
      chk("f_idle_after", 32'(bus_req), 32'd0);

      // Data write, bus values latched at grant and held until ack
      cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; #1;
      chk("w_idle_wait", 32'(d_wait), 32'd1);
      cyc(); d_wdata = 32'h0; #1;
      chk("w_bus_req",   32'(bus_req), 32'd1);
      chk("w_bus_we",    32'(bus_we), 32'd1);
      chk("w_bus_addr",  bus_addr, 32'h2000);
      chk("w_bus_wdata", bus_wdata, 32'hDEADBEEF);
      chk("w_wait_n1",   32'(d_wait), 32'd1);
      cyc(); #1;
      chk("w_hold_wdata", bus_wdata, 32'hDEADBEEF);
      chk("w_hold_addr",  bus_addr, 32'h2000);
      chk("w_wait_n2",    32'(d_wait), 32'd1);
      cyc(); bus_ack = 1'b1; #1;
      chk("w_wait_ack", 32'(d_wait), 32'd0);
      chk("w_i_wait",   32'(i_wait), 32'd1);
      // Second write (wdata 0) granted back-to-back; dropped but still on bus
      cyc(); d_req = 1'b0; #1;
      chk("w2_bus_we",    32'(bus_we), 32'd1);
      chk("w2_bus_wdata", bus_wdata, 32'h0);
      chk("w2_drop_wait", 32'(d_wait), 32'd1);
      cyc(); bus_ack = 1'b0; d_we = 1'b0; #1;
      chk("w_idle_after", 32'(bus_req), 32'd0);

      // Both requesting, immediate acks: I,D,I,D with no bus_req gap
      cyc(); i_req = 1'b1; d_req = 1'b1; i_addr = 32'h300; d_addr = 32'h400; #1;
      chk("rr_idle_iw", 32'(i_wait), 32'd1);
      chk("rr_idle_dw", 32'(d_wait), 32'd1);
      cyc(); bus_ack = 1'b1; bus_rdata = 32'h11; #1;
      chk("rr1_addr", bus_addr, 32'h300);
      chk("rr1_req",  32'(bus_req), 32'd1);
      chk("rr1_iw",   32'(i_wait), 32'd0);
      chk("rr1_dw",   32'(d_wait), 32'd1);
      chk("rr1_data", i_data, 32'h11);
      cyc(); bus_rdata = 32'h22; #1;
      chk("rr2_addr", bus_addr, 32'h400);
      chk("rr2_req",  32'(bus_req), 32'd1);
      chk("rr2_dw",   32'(d_wait), 32'd0);
      chk("rr2_iw",   32'(i_wait), 32'd1);
      chk("rr2_data", d_rdata, 32'h22);
      cyc(); #1;
      chk("rr3_addr", bus_addr, 32'h300);
      chk("rr3_req",  32'(bus_req), 32'd1);
      cyc(); #1;
      chk("rr4_addr", bus_addr, 32'h400);
      chk("rr4_req",  32'(bus_req), 32'd1);
      i_req = 1'b0; d_req = 1'b0; #1;
      chk("rr4_drop_dw", 32'(d_wait), 32'd1);
      cyc(); bus_ack = 1'b0; #1;
      chk("rr_idle_after", 32'(bus_req), 32'd0);

      // Fetch drops its request after grant; ack three cycles later
      cyc(); i_req = 1'b1; i_addr = 32'h500; #1;
      cyc(); i_req = 1'b0; #1;
      chk("dr_req_n1",  32'(bus_req), 32'd1);
      chk("dr_addr",    bus_addr, 32'h500);
      chk("dr_wait_n1", 32'(i_wait), 32'd1);
      cyc(); #1;
      chk("dr_req_n2",  32'(bus_req), 32'd1);
      cyc(); #1;
      chk("dr_req_n3",  32'(bus_req), 32'd1);
      chk("dr_wait_n3", 32'(i_wait), 32'd1);
      cyc(); bus_ack = 1'b1; #1;
      chk("dr_wait_ack", 32'(i_wait), 32'd1);
      chk("dr_req_ack",  32'(bus_req), 32'd1);
      // bus_ack held high into IDLE must be ignored
      cyc(); #1;
      chk("dr_idle_req",  32'(bus_req), 32'd0);
      chk("idle_ack_iw",  32'(i_wait), 32'd1);
      chk("idle_ack_dw",  32'(d_wait), 32'd1);
      cyc(); bus_ack = 1'b0; #1;
      chk("idle_ack_req", 32'(bus_req), 32'd0);

      // Reset while BUSY_D; fetch was served last, so only reset makes the tie go to fetch
      cyc(); d_req = 1'b1; d_addr = 32'h600; #1;
      cyc(); #1;
      chk("rs_busy_req",  32'(bus_req), 32'd1);
      chk("rs_busy_addr", bus_addr, 32'h600);
      bus_ack = 1'b1; Nrst = 1'b0; #1;
      chk("rs_bus_req", 32'(bus_req), 32'd0);
      chk("rs_i_wait",  32'(i_wait), 32'd1);
      chk("rs_d_wait",  32'(d_wait), 32'd1);
      chk("rs_addr",    bus_addr, 32'h0);
      cyc(); Nrst = 1'b1; bus_ack = 1'b0; i_req = 1'b1; d_req = 1'b1;
      i_addr = 32'h700; d_addr = 32'h800; #1;
      cyc(); #1;
      chk("rs_tie_addr", bus_addr, 32'h700);
      chk("rs_tie_we",   32'(bus_we), 32'd0);
      i_req = 1'b0; d_req = 1'b0; bus_ack = 1'b1;
      cyc(); bus_ack = 1'b0; #1;
      chk("rs_idle_after", 32'(bus_req), 32'd0);

`ifdef MEM_ARBITER_PERFCNT_EN
      // Four alternating grants; stalled cycles: R0 (i), R1 (d), R2 (i), R3 (d)
      Nrst = 1'b0; #1;
      chk("pf_rst_i", perf_i_grants, 32'd0);
      chk("pf_rst_d", perf_d_grants, 32'd0);
      chk("pf_rst_c", perf_conflict, 32'd0);
      cyc(); Nrst = 1'b1;
      cyc(); i_req = 1'b1; i_addr = 32'h900; d_addr = 32'hA00; #1;
      cyc(); d_req = 1'b1; bus_ack = 1'b1; #1;
      chk("pf_g1", bus_addr, 32'h900);
      cyc(); #1;
      chk("pf_g2", bus_addr, 32'hA00);
      cyc(); #1;
      chk("pf_g3", bus_addr, 32'h900);
      cyc(); #1;
      chk("pf_g4", bus_addr, 32'hA00);
      i_req = 1'b0; d_req = 1'b0;
      cyc(); bus_ack = 1'b0; #1;
      chk("pf_idle",   32'(bus_req), 32'd0);
      chk("pf_i_grants", perf_i_grants, 32'd2);
      chk("pf_d_grants", perf_d_grants, 32'd2);
      chk("pf_conflict", perf_conflict, 32'd4);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter that shares a single memory bus between the instruction-fetch read port and the data-side load/store port. It sits between the fetch stage and the memory/cache bus. Each requester sees the same combinational-wait handshake the fetch stage already uses. Grants alternate round-robin so neither side starves. Each transaction's address and data are latched at grant, so the bus stays stable even if a requester drops its request mid-flight.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clk` in 1: clock.
- `Nrst` in 1: reset, asynchronous, active-low.
- `i_addr` in ADDR_W: fetch read address.
- `i_req` in 1: fetch read request.
- `i_wait` out 1: fetch wait. Low means `i_data` is valid this cycle.
- `i_data` out DATA_W: fetch read data.
- `d_addr` in ADDR_W: data-port address.
- `d_req` in 1: data-port request.
- `d_we` in 1: data-port write enable.
- `d_wdata` in DATA_W: data-port write data.
- `d_wait` out 1: data-port wait. Low means the access completed this cycle.
- `d_rdata` out DATA_W: data-port read data.
- `bus_addr` out ADDR_W: bus address (registered).
- `bus_req` out 1: bus request (registered).
- `bus_we` out 1: bus write enable (registered).
- `bus_wdata` out DATA_W: bus write data (registered).
- `bus_ack` in 1: single-cycle completion. `bus_rdata` is valid in the same cycle.
- `bus_rdata` in DATA_W: bus read data.

## Operation
- States:
  - IDLE: no transaction.
  - BUSY_I: fetch transaction in flight.
  - BUSY_D: data transaction in flight.
- `last_i` flag records which requester was served most recently. It is 0 after reset.
- Pick rule:
  - Only one request present: that request wins.
  - Both present: the requester not served last wins.
  - On reset, `last_i`=0, so the first tie goes to fetch.
- Transitions:
  - IDLE to BUSY_x on a clock edge where the pick yields x. At that edge, latch `x_addr`, `x_we` (0 for fetch) and `x_wdata` into the bus registers, and set `bus_req`=1.
  - BUSY_x on the edge where `bus_ack`=1:
    - Set `last_i` from the completed transaction.
    - Re-run the pick on the current requests.
    - If a request is pending, go directly to its BUSY state and load the new bus registers (back-to-back, no idle cycle).
    - Otherwise go to IDLE and set `bus_req`=0.
  - BUSY_x with `bus_ack`=0: hold all state.
- Waits and data:
  - `x_wait` = !(state==BUSY_x && bus_ack && x_req). This is combinational.
  - `i_data` = `d_rdata` = `bus_rdata`, passed through combinationally.
- Requester drops `x_req` while its transaction is in flight:
  - The bus transaction still completes. The bus holds until ack.
  - Read data is discarded and no wait-low pulse is produced.
  - A dropped write still commits.
- A requester must keep its address stable while `x_req` is high and `x_wait` is high. The arbiter does not compare addresses; it returns data for the latched address.
- `bus_ack` while in IDLE is ignored.

## Timing
- Reset values: state IDLE, `last_i`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `i_wait`=1, `d_wait`=1.
- Minimum latency:
  - Request raised in cycle N, so the grant edge is at the end of N.
  - `bus_req` goes high in N+1.
  - With ack in N+1, `x_wait` is low in N+1.
- Back-to-back throughput is one transaction per bus-ack cycle.
- Simultaneous events in the ack cycle: a new request and a completion in the same cycle resolve per the pick rule at that edge.
- Reset mid-transaction returns to IDLE immediately and drops `bus_req`. The bus side shares `Nrst` and abandons the access.

## Configuration
- `MEM_ARBITER_PERFCNT_EN` defined:
  - Adds three 32-bit output ports: `perf_i_grants`, `perf_d_grants`, `perf_conflict`.
  - `perf_i_grants` and `perf_d_grants` increment on each grant edge.
  - `perf_conflict` increments each cycle in which a requester has `x_req`=1 and `x_wait`=1.
  - All three reset to 0 and wrap modulo 2^32.
- `MEM_ARBITER_PERFCNT_EN` undefined: these ports and counters do not exist, and arbitration behaviour is identical.

## Structure
- Package `mem_arbiter_pkg` holds:
  - The state enum: IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2.
  - The grant encoding.
- Sub-module `mem_arbiter_pick`: purely combinational round-robin picker.
  - Inputs: `i_req`, `d_req`, `last_i`.
  - Outputs: `grant_valid`, `grant_i`.
  - Instantiated once and used for both the IDLE and the ack-edge decisions.

## Test plan
- Fetch only, `i_addr`=0x100, ack 2 cycles after `bus_req` rises:
  - `bus_addr`=0x100 with `bus_we`=0.
  - `i_wait` low exactly in the ack cycle.
  - `i_data` equals `bus_rdata`.
- Both requesting continuously from reset, immediate acks:
  - Grants alternate I,D,I,D.
  - `bus_req` never drops between transactions.
- Data write `d_addr`=0x2000, `d_wdata`=0xDEADBEEF:
  - `bus_we`=1 and the bus holds these values until ack.
  - `d_wait` low only in the ack cycle.
- Fetch drops `i_req` after grant, ack arrives 3 cycles later:
  - `bus_req` stays high until ack.
  - `i_wait` stays high throughout.
  - The arbiter returns to IDLE afterwards.
- `Nrst` asserted while in BUSY_D:
  - Same cycle: `bus_req`=0, both waits=1.
  - After release, the first tie is granted to fetch.
- With `MEM_ARBITER_PERFCNT_EN` and four alternating grants:
  - `perf_i_grants`=2 and `perf_d_grants`=2.
  - `perf_conflict` equals the number of cycles with a request pending and its wait high.
